// File: rtl/rf_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package rf_arb_pkg;
  localparam int RF_DATA_W = 8;
  localparam int RF_ADDR_W = 3;

  typedef enum logic {ST_CLEAR, ST_RUN} arb_state_t;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a one-bit "last granted" pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);
  logic last;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        last <= 1'b1;
    else if (accept) last <= grant[1];
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load writebacks onto the single register-file write port.
// Define RF_ARB_CLEAR_EN to compile in the post-reset clearing sweep.
module regfile_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W      = RF_DATA_W,
  parameter int ADDR_W      = RF_ADDR_W,
  parameter bit ZERO_REG_RO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0] wd3,
  output logic              busy
);
  logic              run;
  logic [1:0]        valid_m;
  logic [1:0]        grant;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              issue;

  assign valid_m    = {req1_valid, req0_valid} & {2{run}};
  assign accept     = |valid_m;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign sel_addr   = grant[1] ? req1_addr : req0_addr;
  assign sel_data   = grant[1] ? req1_data : req0_data;
  assign issue      = !(ZERO_REG_RO && (sel_addr == '0));

  rr_arb2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .valid  (valid_m),
    .accept (accept),
    .grant  (grant)
  );

`ifdef RF_ARB_CLEAR_EN
  arb_state_t        state;
  logic [ADDR_W-1:0] cnt;

  assign run  = (state == ST_RUN);
  assign busy = (state == ST_CLEAR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      we3   <= 1'b0;
      wa3   <= '0;
      wd3   <= '0;
    end else if (state == ST_CLEAR) begin
      we3 <= 1'b1;
      wa3 <= cnt;
      wd3 <= '0;
      cnt <= cnt + 1'b1;
      if (cnt == '1) state <= ST_RUN;
    end else begin
      we3 <= accept && issue;
      if (accept) begin
        wa3 <= sel_addr;
        wd3 <= sel_data;
      end
    end
  end
`else
  assign run  = 1'b1;
  assign busy = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else begin
      we3 <= accept && issue;
      if (accept) begin
        wa3 <= sel_addr;
        wd3 <= sel_data;
      end
    end
  end
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed-vector bench for regfile_write_arbiter with a behavioural register file.
module tb_regfile_write_arbiter;
  import rf_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [2:0] req0_addr = '0, req1_addr = '0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready, we3, busy;
  logic [2:0] wa3;
  logic [7:0] wd3;
  logic [7:0] rfm [8];

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_W(8), .ADDR_W(3), .ZERO_REG_RO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .we3(we3), .wa3(wa3), .wd3(wd3), .busy(busy)
  );

  initial for (int i = 0; i < 8; i++) rfm[i] = 8'h55;
  always @(posedge clk) if (we3) rfm[wa3] <= wd3;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input int unsigned idx, input logic v, input wb_req_t r);
    if (idx == 0) begin
      req0_valid = v; req0_addr = r.addr; req0_data = r.data;
    end else begin
      req1_valid = v; req1_addr = r.addr; req1_data = r.data;
    end
  endtask

  task automatic post_edge();
    @(posedge clk); #1;
  endtask

  task automatic check_sweep(input string tag);
`ifdef RF_ARB_CLEAR_EN
    for (int unsigned i = 0; i < 8; i++) begin
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_rdy"}, {req1_ready, req0_ready}, 0);
      post_edge();
      chk({tag, "_we"}, we3, 1);
      chk({tag, "_wa"}, wa3, i);
      chk({tag, "_wd"}, wd3, 0);
    end
    @(negedge clk);
`endif
    chk({tag, "_done"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_we", we3, 0);
    chk("rst_wa", wa3, 0);
    chk("rst_wd", wd3, 0);
    chk("rst_rdy", {req1_ready, req0_ready}, 0);
`ifdef RF_ARB_CLEAR_EN
    chk("rst_busy", busy, 1);
`else
    chk("rst_busy", busy, 0);
`endif
    // single requester held across any sweep
    drive(0, 1'b1, '{addr: 3'd1, data: 8'hCA});
    rst = 1'b1;
    check_sweep("sweep");
    #1;
    chk("single_rdy0", req0_ready, 1);
    chk("single_rdy1", req1_ready, 0);
    post_edge();
    chk("single_we", we3, 1);
    chk("single_wa", wa3, 1);
    chk("single_wd", wd3, 8'hCA);
    @(negedge clk);
    drive(0, 1'b0, '{addr: 3'd0, data: 8'h00});
    post_edge();
    chk("single_rf1", rfm[1], 8'hCA);
    chk("idle_we", we3, 0);
    chk("idle_wd_hold", wd3, 8'hCA);

    // zero register: accepted, not issued
    @(negedge clk);
    drive(1, 1'b1, '{addr: 3'd0, data: 8'hDB});
    #1;
    chk("zero_rdy1", req1_ready, 1);
    post_edge();
    chk("zero_we", we3, 0);
    @(negedge clk);
    drive(1, 1'b0, '{addr: 3'd0, data: 8'h00});
    post_edge();
`ifdef RF_ARB_CLEAR_EN
    chk("zero_rf0", rfm[0], 8'h00);
`else
    chk("zero_rf0", rfm[0], 8'h55);
`endif

    // contention: grants alternate starting with req0
    @(negedge clk);
    drive(0, 1'b1, '{addr: 3'd7, data: 8'hFE});
    drive(1, 1'b1, '{addr: 3'd2, data: 8'h34});
    for (int unsigned k = 0; k < 4; k++) begin
      #1;
      chk("cont_rdy", {req1_ready, req0_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
      post_edge();
      chk("cont_we", we3, 1);
      chk("cont_wa", wa3, (k % 2 == 0) ? 3'd7 : 3'd2);
      chk("cont_wd", wd3, (k % 2 == 0) ? 8'hFE : 8'h34);
      @(negedge clk);
    end
    drive(1, 1'b0, '{addr: 3'd0, data: 8'h00});

    // reset in the cycle after an accept discards the pending write
    drive(0, 1'b1, '{addr: 3'd5, data: 8'h29});
    #1;
    chk("mid_rdy0", req0_ready, 1);
    post_edge();
    chk("mid_we_pre", we3, 1);
    drive(0, 1'b0, '{addr: 3'd0, data: 8'h00});
    #1;
    rst = 1'b0;
    #1;
    chk("mid_we", we3, 0);
    chk("mid_wa", wa3, 0);
    chk("mid_wd", wd3, 0);
    post_edge();
`ifdef RF_ARB_CLEAR_EN
    chk("mid_rf5", rfm[5], 8'h00);
`else
    chk("mid_rf5", rfm[5], 8'h55);
`endif

    // same address from reset release: req0 first, req1 lands last
    @(negedge clk);
    drive(0, 1'b1, '{addr: 3'd3, data: 8'h11});
    drive(1, 1'b1, '{addr: 3'd3, data: 8'h22});
    rst = 1'b1;
    check_sweep("resweep");
    #1;
    chk("same_rdy_a", {req1_ready, req0_ready}, 2'b01);
    post_edge();
    chk("same_wd_a", wd3, 8'h11);
    @(negedge clk);
    chk("same_rdy_b", {req1_ready, req0_ready}, 2'b10);
    post_edge();
    chk("same_wa_b", wa3, 3);
    chk("same_wd_b", wd3, 8'h22);
    @(negedge clk);
    drive(0, 1'b0, '{addr: 3'd0, data: 8'h00});
    drive(1, 1'b0, '{addr: 3'd0, data: 8'h00});
    post_edge();
    chk("same_rf3", rfm[3], 8'h22);
    chk("same_idle_we", we3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
